median5x5_filter: RTL
=====================

// Module: median5x5_filter
// PURPOSE
//  Per-channel 5x5 median over the window from hdmi_buffer; sits between it and the HDMI TX.
//  Takes the five 5-pixel rows plus kernel_valid, outputs one filtered RGB pixel per clock.
//  Carries rx_dv/rx_hs/rx_vs through an equal-length delay so the TX sees aligned timing.
// PARAMETERS
//  CH_W     8   bits per colour channel; pixel = {R,G,B}, 3*CH_W wide
//  LATENCY  3   fixed pipeline depth, input edge to output; not overridable, exported for benches
// PORTS
//  clk           in   1         system clock, single clock domain
//  rst           in   1         synchronous reset, active-high
//  bypass        in   1         1: output centre pixel unfiltered (still LATENCY delayed)
//  kernel_row_1  in   5*3*CH_W  window row 1 (top); pixel c (0=oldest) at [c*3*CH_W +: 3*CH_W]
//  kernel_row_2..kernel_row_5  in  5*3*CH_W  rows 2..5, same packing; row 5 = newest line
//  kernel_valid  in   1         window fully populated from real image lines
//  in_dv         in   1         pixel-valid strobe aligned with the window
//  in_hs, in_vs  in   1 each    hsync/vsync aligned with the window
//  out_red, out_green, out_blue  out  CH_W each   filtered pixel
//  out_dv, out_hs, out_vs        out  1 each      in_* delayed by exactly LATENCY cycles
// BEHAVIOUR
//  - Reset: all pipeline registers and all outputs 0 on the first clk edge with rst=1.
//  - Reset mid-stream clears in-flight data. First valid out_dv is LATENCY edges after rst drops.
//  - Streaming: one window accepted every clk, no back-pressure; each in_dv=1 edge gives out_dv=1
//    exactly LATENCY cycles later.
//  - Stage S0: register the 25 pixels, kernel_valid, bypass, in_dv/hs/vs.
//  - Stage S1: per channel, form a comparison matrix and register it.
//    lt[i][j] = x_j < x_i; eq_lo[i][j] = (x_j == x_i) and j < i; i,j in 0..24, i != j.
//  - Stage S2: rank_i = popcount(lt[i][*]) + popcount(eq_lo[i][*]), a 5-bit unsigned value.
//    Tie-break by index makes the ranks a permutation of 0..24.
//    Exactly one i has rank 12; median = OR-reduce of (x_i masked by rank_i==12). No arithmetic overflow.
//  - Output select, registered at the end of S2:
//    bypass=1 or kernel_valid=0 -> centre pixel (row 3, col 2). Otherwise -> per-channel medians.
//  - Channels are independent: R, G and B medians may come from different pixel positions.
//  - Inputs are sampled every cycle regardless of in_dv. Data with in_dv=0 is don't-care but deterministic.
//  - bypass and kernel_valid travel with their own window, so a toggle applies to that pixel only.
//  - in_vs/in_hs have no internal effect; they are only delayed. Frame boundaries need no flush.
// STRUCTURE
//  - Shared package median_pkg: CH_W, PX_W=3*CH_W, KSIZE=5, KAREA=25, MED_RANK=12, LATENCY=3,
//    and a function px_at(row_bus, c) for pixel extraction.
//  - Sub-module median25_ch: one channel, 25xCH_W in -> CH_W median.
//    Holds the S1/S2 registers and is instantiated 3 times (R, G, B).
//  - Top level holds S0, the sync/flag delay lines, centre-pixel delay and output mux.
// TESTING
//  1. All 25 pixels 0x808080, kernel_valid=1, in_dv=1 -> out pixel 0x808080, out_dv=1 exactly 3 cycles later.
//  2. R values = permutation of 0..24, G=B=0x00 -> out_red=12, out_green=out_blue=0.
//  3. 24 pixels 0x101010 plus one impulse 0xFFFFFF, at every one of the 25 positions in turn -> always 0x101010.
//  4. Ties: 13 pixels R=5 and 12 pixels R=200 -> out_red=5; then 12x5 and 13x200 -> out_red=200.
//  5. kernel_valid=0 (then bypass=1), centre=0x123456, rest 0 -> out 0x123456; median is taken again the next cycle.
//  6. Stream of 10 windows, rst=1 pulsed on window 5 -> outputs and out_dv/hs/vs read 0.
//     Windows 6..10 come out intact 3 cycles after each is applied; in_hs/in_vs pulses appear shifted by exactly 3.

Source files
------------

// File: rtl/median_pkg.sv
// Shared constants and pixel-extraction helper for the 5x5 median filter.
package median_pkg;
  localparam int CH_W     = 8;
  localparam int PX_W     = 3 * CH_W;
  localparam int KSIZE    = 5;
  localparam int KAREA    = KSIZE * KSIZE;
  localparam int ROW_W    = KSIZE * PX_W;
  localparam int MED_RANK = 12;
  localparam int CENTRE   = (KSIZE / 2) * KSIZE + (KSIZE / 2);
  localparam int RANK_W   = 5;
  localparam int LATENCY  = 3;

  // Pixel c of a packed row, c=0 being the oldest sample.
  function automatic logic [PX_W-1:0] px_at(input logic [ROW_W-1:0] row_bus, input int c);
    return row_bus[c*PX_W +: PX_W];
  endfunction
endpackage

// File: rtl/median25_ch.sv
// Purpose: single-channel median of 25 samples via rank counting, with centre-pass option.
// Latency: 2 register stages (S1 compare matrix, S2 rank select + output mux).
// Backpressure: none; a new sample set is taken every clock.
module median25_ch
  import median_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KAREA*CH_W-1:0] x_flat,
  input  logic [CH_W-1:0]       centre,
  input  logic                  use_centre,
  output logic [CH_W-1:0]       med
);
  logic [CH_W-1:0]   x      [KAREA];
  logic [KAREA-1:0]  lt_d   [KAREA];
  logic [KAREA-1:0]  eqlo_d [KAREA];
  logic [CH_W-1:0]   x_q    [KAREA];
  logic [KAREA-1:0]  lt_q   [KAREA];
  logic [KAREA-1:0]  eqlo_q [KAREA];
  logic [RANK_W-1:0] rank   [KAREA];
  logic [CH_W-1:0]   med_d;

  function automatic logic [RANK_W-1:0] popcnt(input logic [KAREA-1:0] v);
    logic [RANK_W-1:0] n;
    n = '0;
    for (int k = 0; k < KAREA; k++) n = n + RANK_W'(v[k]);
    return n;
  endfunction

  always_comb begin
    for (int i = 0; i < KAREA; i++) x[i] = x_flat[i*CH_W +: CH_W];
  end

  // Equal samples are ordered by index so the ranks form a permutation of 0..24.
  always_comb begin
    for (int i = 0; i < KAREA; i++) begin
      for (int j = 0; j < KAREA; j++) begin
        lt_d[i][j]   = x[j] < x[i];
        eqlo_d[i][j] = (j < i) && (x[j] == x[i]);
      end
    end
  end

  // lt and eq_lo rows are disjoint, so OR-then-count equals the sum of both counts.
  always_comb begin
    med_d = '0;
    for (int i = 0; i < KAREA; i++) begin
      rank[i] = popcnt(lt_q[i] | eqlo_q[i]);
      if (rank[i] == RANK_W'(MED_RANK)) med_d = med_d | x_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KAREA; i++) begin
        x_q[i]    <= '0;
        lt_q[i]   <= '0;
        eqlo_q[i] <= '0;
      end
      med <= '0;
    end else begin
      for (int i = 0; i < KAREA; i++) begin
        x_q[i]    <= x[i];
        lt_q[i]   <= lt_d[i];
        eqlo_q[i] <= eqlo_d[i];
      end
      med <= use_centre ? centre : med_d;
    end
  end
endmodule

// File: rtl/median5x5_filter.sv
// Purpose: per-channel 5x5 median between hdmi_buffer and HDMI TX, syncs delayed to match.
// Latency: LATENCY (3) cycles, window capture edge to output register.
// Backpressure: none; one window in and one pixel out every clock.
module median5x5_filter
  import median_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bypass,
  input  logic [ROW_W-1:0] kernel_row_1,
  input  logic [ROW_W-1:0] kernel_row_2,
  input  logic [ROW_W-1:0] kernel_row_3,
  input  logic [ROW_W-1:0] kernel_row_4,
  input  logic [ROW_W-1:0] kernel_row_5,
  input  logic             kernel_valid,
  input  logic             in_dv,
  input  logic             in_hs,
  input  logic             in_vs,
  output logic [CH_W-1:0]  out_red,
  output logic [CH_W-1:0]  out_green,
  output logic [CH_W-1:0]  out_blue,
  output logic             out_dv,
  output logic             out_hs,
  output logic             out_vs
);
  logic [ROW_W-1:0]      rows  [KSIZE];
  logic [PX_W-1:0]       win_q [KAREA];
  logic                  kv_q;
  logic                  byp_q;
  logic [PX_W-1:0]       centre_s1;
  logic                  use_centre_s1;
  logic [KAREA*CH_W-1:0] r_flat;
  logic [KAREA*CH_W-1:0] g_flat;
  logic [KAREA*CH_W-1:0] b_flat;
  logic [LATENCY-1:0]    dv_sr;
  logic [LATENCY-1:0]    hs_sr;
  logic [LATENCY-1:0]    vs_sr;

  always_comb begin
    rows[0] = kernel_row_1;
    rows[1] = kernel_row_2;
    rows[2] = kernel_row_3;
    rows[3] = kernel_row_4;
    rows[4] = kernel_row_5;
  end

  // Window flags ride with their own pixel: resolved to one select bit in S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KAREA; i++) win_q[i] <= '0;
      kv_q          <= 1'b0;
      byp_q         <= 1'b0;
      centre_s1     <= '0;
      use_centre_s1 <= 1'b0;
      dv_sr         <= '0;
      hs_sr         <= '0;
      vs_sr         <= '0;
    end else begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) win_q[r*KSIZE + c] <= px_at(rows[r], c);
      end
      kv_q          <= kernel_valid;
      byp_q         <= bypass;
      centre_s1     <= win_q[CENTRE];
      use_centre_s1 <= byp_q | ~kv_q;
      dv_sr         <= {dv_sr[LATENCY-2:0], in_dv};
      hs_sr         <= {hs_sr[LATENCY-2:0], in_hs};
      vs_sr         <= {vs_sr[LATENCY-2:0], in_vs};
    end
  end

  always_comb begin
    r_flat = '0;
    g_flat = '0;
    b_flat = '0;
    for (int i = 0; i < KAREA; i++) begin
      r_flat[i*CH_W +: CH_W] = win_q[i][3*CH_W-1 -: CH_W];
      g_flat[i*CH_W +: CH_W] = win_q[i][2*CH_W-1 -: CH_W];
      b_flat[i*CH_W +: CH_W] = win_q[i][CH_W-1:0];
    end
  end

  median25_ch u_red (
    .clk        (clk),
    .rst        (rst),
    .x_flat     (r_flat),
    .centre     (centre_s1[3*CH_W-1 -: CH_W]),
    .use_centre (use_centre_s1),
    .med        (out_red)
  );

  median25_ch u_green (
    .clk        (clk),
    .rst        (rst),
    .x_flat     (g_flat),
    .centre     (centre_s1[2*CH_W-1 -: CH_W]),
    .use_centre (use_centre_s1),
    .med        (out_green)
  );

  median25_ch u_blue (
    .clk        (clk),
    .rst        (rst),
    .x_flat     (b_flat),
    .centre     (centre_s1[CH_W-1:0]),
    .use_centre (use_centre_s1),
    .med        (out_blue)
  );

  assign out_dv = dv_sr[LATENCY-1];
  assign out_hs = hs_sr[LATENCY-1];
  assign out_vs = vs_sr[LATENCY-1];
endmodule
